toy_bus_pkt_lock_credit_arb: RTL and testbench

//   Two-input, one-output arbiter for a toy_bus network node carrying multi-beat packets.
//   - Grants requesters in age order: the most recently served input becomes the youngest.
//   - Holds the grant from the first beat of a packet through its last beat.
//   - Meters the output with a credit counter, so out0 has no ready signal.
//   - Sits between the node decoders and a credit-return link toward the next hop.

---
 rtl/toy_bus_pkt_lock_credit_arb.sv | 148 ++++++++++++++
 tb/tb_toy_bus_pkt_lock_credit_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_pkt_lock_credit_arb.sv
// ---------------------------------------------------------------------------
// toy_bus_pkt_lock_credit_arb
//   Two-input, one-output packet arbiter for a toy_bus node. Grants in age
//   order, holds the grant for the whole multi-beat packet and meters out0
//   with a credit counter fed by a credit-return link (out0 has no ready).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   inN_vld / inN_rdy           request handshake, N = 0,1
//   inN_opcode/data/sideband/
//   inN_src_id/tgt_id/last      beat fields of input N
//   out0_vld                    beat sent this cycle (consumes one credit)
//   out0_opcode/.../last        fields of the granted input, 0 when idle
//   crd_rtn                     one credit returned per cycle when high
//   crd_avail                   current credit count
//   crd_ovf_err                 sticky: credit returned while already full
//   state_dbg                   FSM state (0 IDLE, 1 LOCK0, 2 LOCK1)
//
// Handshake: a beat on inN transfers in any cycle where inN_vld && inN_rdy.
// inN_rdy never depends on inN_vld's own beat content beyond the grant, and
// never on anything downstream; out0_vld is the same-cycle transfer.
// ---------------------------------------------------------------------------
module toy_bus_pkt_lock_credit_arb #(
   parameter int DATA_W  = 256,
   parameter int SB_W    = 10,
   parameter int ID_W    = 4,
   parameter int CRD_MAX = 4,
   parameter int CRD_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_vld,
   output logic              in0_rdy,
   input  logic              in0_opcode,
   input  logic [DATA_W-1:0] in0_data,
   input  logic [SB_W-1:0]   in0_sideband,
   input  logic [ID_W-1:0]   in0_src_id,
   input  logic [ID_W-1:0]   in0_tgt_id,
   input  logic              in0_last,
   input  logic              in1_vld,
   output logic              in1_rdy,
   input  logic              in1_opcode,
   input  logic [DATA_W-1:0] in1_data,
   input  logic [SB_W-1:0]   in1_sideband,
   input  logic [ID_W-1:0]   in1_src_id,
   input  logic [ID_W-1:0]   in1_tgt_id,
   input  logic              in1_last,
   output logic              out0_vld,
   output logic              out0_opcode,
   output logic [DATA_W-1:0] out0_data,
   output logic [SB_W-1:0]   out0_sideband,
   output logic [ID_W-1:0]   out0_src_id,
   output logic [ID_W-1:0]   out0_tgt_id,
   output logic              out0_last,
   input  logic              crd_rtn,
   output logic [CRD_W-1:0]  crd_avail,
   output logic              crd_ovf_err,
   output logic [1:0]        state_dbg
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOCK0 = 2'd1;
   localparam logic [1:0] ST_LOCK1 = 2'd2;
   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CRD_MAX);

   logic [1:0]       state_q, state_d;
   logic             age_q, age_d;     // 0: in0 older, 1: in1 older
   logic [CRD_W-1:0] crd_q, crd_d;
   logic             err_q, err_d;
   logic [1:0]       gnt;              // one-hot, already qualified by credit
   logic             fire;
   logic             ovf;

   // Grant: a lock pins the grant to its owner; a gap in the owner's valid
   // leaves nobody granted rather than letting the other input slip in.
   always_comb begin
      gnt = 2'b00;
      case (state_q)
         ST_LOCK0: gnt[0] = in0_vld;
         ST_LOCK1: gnt[1] = in1_vld;
         default: begin
            if (in0_vld && in1_vld) gnt = age_q ? 2'b10 : 2'b01;
            else                    gnt = {in1_vld, in0_vld};
         end
      endcase
      if (crd_q == '0) gnt = 2'b00;
   end

   assign in0_rdy = gnt[0];
   assign in1_rdy = gnt[1];
   assign fire    = |gnt;   // grant implies valid, so any grant is a transfer

   assign out0_vld      = fire;
   assign out0_opcode   = (gnt[0] & in0_opcode) | (gnt[1] & in1_opcode);
   assign out0_data     = ({DATA_W{gnt[0]}} & in0_data)     | ({DATA_W{gnt[1]}} & in1_data);
   assign out0_sideband = ({SB_W{gnt[0]}}   & in0_sideband) | ({SB_W{gnt[1]}}   & in1_sideband);
   assign out0_src_id   = ({ID_W{gnt[0]}}   & in0_src_id)   | ({ID_W{gnt[1]}}   & in1_src_id);
   assign out0_tgt_id   = ({ID_W{gnt[0]}}   & in0_tgt_id)   | ({ID_W{gnt[1]}}   & in1_tgt_id);
   assign out0_last     = (gnt[0] & in0_last) | (gnt[1] & in1_last);

   // Lock and age only move on a transfer; a last beat releases the lock and
   // makes the sender the younger input (gnt[0] == 1 -> in1 becomes older).
   always_comb begin
      state_d = (state_q == 2'b11) ? ST_IDLE : state_q;
      age_d   = age_q;
      if (fire) begin
         if (out0_last) begin
            state_d = ST_IDLE;
            age_d   = gnt[0];
         end else begin
            state_d = gnt[0] ? ST_LOCK0 : ST_LOCK1;
         end
      end
   end

   // Credits: a send and a return in the same cycle cancel out. A return with
   // the counter already full saturates and flags an upstream protocol bug.
   assign ovf = crd_rtn && !fire && (crd_q == CRD_FULL);

   always_comb begin
      crd_d = crd_q;
      case ({fire, crd_rtn})
         2'b10:   crd_d = crd_q - 1'b1;
         2'b01:   crd_d = ovf ? crd_q : crd_q + 1'b1;
         default: crd_d = crd_q;
      endcase
      err_d = err_q | ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         age_q   <= 1'b0;
         crd_q   <= CRD_FULL;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
         crd_q   <= crd_d;
         err_q   <= err_d;
      end
   end

   assign crd_avail   = crd_q;
   assign crd_ovf_err = err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_toy_bus_pkt_lock_credit_arb.sv
// ---------------------------------------------------------------------------
// tb_toy_bus_pkt_lock_credit_arb
//   Bench for the two-input packet-lock credit arbiter: a table of directed
//   vectors, hand-written multi-cycle sequences and a randomized run, all
//   checked against a small behavioural model (owner / older input / credit
//   integer) kept in this file.
// ---------------------------------------------------------------------------
module tb_toy_bus_pkt_lock_credit_arb;

   localparam int DATA_W  = 256;
   localparam int SB_W    = 10;
   localparam int ID_W    = 4;
   localparam int CRD_MAX = 4;
   localparam int CRD_W   = 3;
   localparam logic [ID_W-1:0] SRC0 = 4'h3;
   localparam logic [ID_W-1:0] SRC1 = 4'hA;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              in0_vld = 0, in0_opcode = 0, in0_last = 0;
   logic [DATA_W-1:0] in0_data = '0;
   logic [SB_W-1:0]   in0_sideband = '0;
   logic [ID_W-1:0]   in0_src_id = SRC0, in0_tgt_id = '0;
   logic              in1_vld = 0, in1_opcode = 0, in1_last = 0;
   logic [DATA_W-1:0] in1_data = '0;
   logic [SB_W-1:0]   in1_sideband = '0;
   logic [ID_W-1:0]   in1_src_id = SRC1, in1_tgt_id = '0;
   logic              crd_rtn = 0;
   logic              in0_rdy, in1_rdy;
   logic              out0_vld, out0_opcode, out0_last;
   logic [DATA_W-1:0] out0_data;
   logic [SB_W-1:0]   out0_sideband;
   logic [ID_W-1:0]   out0_src_id, out0_tgt_id;
   logic [CRD_W-1:0]  crd_avail;
   logic              crd_ovf_err;
   logic [1:0]        state_dbg;

   toy_bus_pkt_lock_credit_arb #(
      .DATA_W(DATA_W), .SB_W(SB_W), .ID_W(ID_W), .CRD_MAX(CRD_MAX), .CRD_W(CRD_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_opcode(in0_opcode), .in0_data(in0_data),
      .in0_sideband(in0_sideband), .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id), .in0_last(in0_last),
      .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_opcode(in1_opcode), .in1_data(in1_data),
      .in1_sideband(in1_sideband), .in1_src_id(in1_src_id), .in1_tgt_id(in1_tgt_id), .in1_last(in1_last),
      .out0_vld(out0_vld), .out0_opcode(out0_opcode), .out0_data(out0_data),
      .out0_sideband(out0_sideband), .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id),
      .out0_last(out0_last),
      .crd_rtn(crd_rtn), .crd_avail(crd_avail), .crd_ovf_err(crd_ovf_err), .state_dbg(state_dbg)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // owner: -1 no packet in progress, else the input holding the output.
   // older: index of the input that wins a tie.
   int m_owner = -1;
   int m_older = 0;
   int m_crd   = CRD_MAX;
   bit m_err   = 0;
   int m_g     = -1;   // input the model expects to transfer this cycle

   task automatic model_reset();
      m_owner = -1; m_older = 0; m_crd = CRD_MAX; m_err = 0; m_g = -1;
   endtask

   function automatic int model_pick();
      if (m_crd == 0) return -1;
      if (m_owner == 0) return in0_vld ? 0 : -1;
      if (m_owner == 1) return in1_vld ? 1 : -1;
      if (in0_vld && in1_vld) return m_older;
      if (in0_vld) return 0;
      if (in1_vld) return 1;
      return -1;
   endfunction

   task automatic model_check();
      logic [DATA_W-1:0] e_data;
      logic [SB_W-1:0]   e_sb;
      logic [ID_W-1:0]   e_src, e_tgt;
      logic              e_op, e_last;
      m_g = model_pick();
      e_data = '0; e_sb = '0; e_src = '0; e_tgt = '0; e_op = 0; e_last = 0;
      if (m_g == 0) begin
         e_data = in0_data; e_sb = in0_sideband; e_src = in0_src_id;
         e_tgt = in0_tgt_id; e_op = in0_opcode; e_last = in0_last;
      end else if (m_g == 1) begin
         e_data = in1_data; e_sb = in1_sideband; e_src = in1_src_id;
         e_tgt = in1_tgt_id; e_op = in1_opcode; e_last = in1_last;
      end
      chk("m_in0_rdy", in0_rdy, (m_g == 0));
      chk("m_in1_rdy", in1_rdy, (m_g == 1));
      chk("m_out0_vld", out0_vld, (m_g >= 0));
      chk("m_out0_data", out0_data, e_data);
      chk("m_out0_sideband", out0_sideband, e_sb);
      chk("m_out0_src_id", out0_src_id, e_src);
      chk("m_out0_tgt_id", out0_tgt_id, e_tgt);
      chk("m_out0_opcode", out0_opcode, e_op);
      chk("m_out0_last", out0_last, e_last);
      chk("m_crd_avail", crd_avail, m_crd);
      chk("m_crd_ovf_err", crd_ovf_err, m_err);
   endtask

   task automatic model_update();
      bit lst;
      if (m_g >= 0) begin
         lst = (m_g == 0) ? in0_last : in1_last;
         if (lst) begin
            m_owner = -1;
            m_older = 1 - m_g;
         end else begin
            m_owner = m_g;
         end
      end
      m_crd = m_crd - ((m_g >= 0) ? 1 : 0) + (crd_rtn ? 1 : 0);
      if (m_crd > CRD_MAX) begin
         m_crd = CRD_MAX;
         m_err = 1;
      end
   endtask

   // ---------------- driver tasks ----------------
   // drive: apply inputs after the falling edge, settle, check against model.
   task automatic drive(input bit v0, input bit l0, input bit v1, input bit l1, input bit rtn);
      @(negedge clk);
      in0_vld = v0; in0_last = l0; in1_vld = v1; in1_last = l1; crd_rtn = rtn;
      in0_opcode = 1'($urandom); in1_opcode = 1'($urandom);
      in0_sideband = SB_W'($urandom); in1_sideband = SB_W'($urandom);
      in0_tgt_id = ID_W'($urandom); in1_tgt_id = ID_W'($urandom);
      for (int i = 0; i < DATA_W / 32; i++) begin
         in0_data[i*32 +: 32] = $urandom;
         in1_data[i*32 +: 32] = $urandom;
      end
      #1;
      model_check();
   endtask

   // adv: take the rising edge in both DUT and model.
   task automatic adv();
      @(posedge clk);
      model_update();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in0_vld = 0; in1_vld = 0; in0_last = 0; in1_last = 0; crd_rtn = 0;
      model_reset();
      #1;
      chk("rst_state", state_dbg, 2'd0);
      chk("rst_crd_avail", crd_avail, CRD_MAX);
      chk("rst_crd_ovf_err", crd_ovf_err, 1'b0);
      chk("rst_out0_vld", out0_vld, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit v0, l0, v1, l1, rtn;
      bit e_rdy0, e_rdy1, e_vld;
      int e_src;
      int e_crd;
   } vec_t;

   vec_t vecs[15];
   int   fires;

   initial begin
      // v0 l0 v1 l1 rtn | rdy0 rdy1 vld src crd(before edge)
      vecs = '{
         '{1,1,1,1,0, 1,0,1, 3, 4},   // both single-beat: in0 older
         '{1,1,1,1,0, 0,1,1,10, 3},   // alternates to in1
         '{0,0,0,0,0, 0,0,0, 0, 2},   // 4 -> 2 credits
         '{1,1,0,0,1, 1,0,1, 3, 2},   // fire + return: stays 2
         '{0,0,0,0,0, 0,0,0, 0, 2},
         '{1,1,1,0,1, 0,1,1,10, 2},   // in1 beat 1 (in1 older), in0 waiting
         '{1,1,0,0,0, 0,0,0, 0, 2},   // gap inside LOCK1: in0 still blocked
         '{1,1,1,0,1, 0,1,1,10, 2},   // beat 2
         '{1,1,1,1,1, 0,1,1,10, 2},   // beat 3 last: lock released
         '{1,1,1,1,0, 1,0,1, 3, 2},   // in0 now granted
         '{1,1,1,1,0, 0,1,1,10, 1},
         '{1,1,1,1,0, 0,0,0, 0, 0},   // out of credits
         '{1,1,1,1,1, 0,0,0, 0, 0},   // return while empty: no grant yet
         '{1,1,1,1,0, 1,0,1, 3, 1},   // one credit -> one beat
         '{0,0,0,0,0, 0,0,0, 0, 0}
      };

      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].v0, vecs[i].l0, vecs[i].v1, vecs[i].l1, vecs[i].rtn);
         chk($sformatf("vec%0d_in0_rdy", i), in0_rdy, vecs[i].e_rdy0);
         chk($sformatf("vec%0d_in1_rdy", i), in1_rdy, vecs[i].e_rdy1);
         chk($sformatf("vec%0d_out0_vld", i), out0_vld, vecs[i].e_vld);
         chk($sformatf("vec%0d_src_id", i), out0_src_id, vecs[i].e_src);
         chk($sformatf("vec%0d_crd_avail", i), crd_avail, vecs[i].e_crd);
         adv();
      end

      // ---- credit exhaustion: 6 beats offered, only 4 go ----
      do_reset();
      fires = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 1, 1, 0);
         if (out0_vld) fires++;
         adv();
      end
      chk("exh_fires", fires, 4);
      drive(1, 1, 1, 1, 0);
      chk("exh_crd_avail", crd_avail, 0);
      chk("exh_in0_rdy", in0_rdy, 1'b0);
      chk("exh_in1_rdy", in1_rdy, 1'b0);
      adv();
      drive(1, 1, 1, 1, 1);
      adv();
      drive(1, 1, 1, 1, 0);
      chk("exh_one_more_vld", out0_vld, 1'b1);
      adv();
      drive(1, 1, 1, 1, 0);
      chk("exh_back_to_zero", crd_avail, 0);
      chk("exh_no_vld", out0_vld, 1'b0);
      adv();

      // ---- credit overflow is sticky ----
      do_reset();
      drive(0, 0, 0, 0, 1);
      adv();
      drive(0, 0, 0, 0, 0);
      chk("ovf_crd_avail", crd_avail, CRD_MAX);
      chk("ovf_err_set", crd_ovf_err, 1'b1);
      adv();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 0);
         adv();
      end
      drive(0, 0, 0, 0, 0);
      chk("ovf_err_sticky", crd_ovf_err, 1'b1);
      adv();

      // ---- reset in the middle of an in0 packet ----
      do_reset();
      drive(1, 0, 1, 1, 0);
      chk("midrst_first_rdy0", in0_rdy, 1'b1);
      adv();
      drive(1, 0, 1, 1, 0);
      chk("midrst_lock0_state", state_dbg, 2'd1);
      chk("midrst_lock0_rdy1", in1_rdy, 1'b0);
      adv();
      do_reset();
      drive(1, 1, 1, 1, 0);
      chk("midrst_idle_state", state_dbg, 2'd0);
      chk("midrst_in0_again", in0_rdy, 1'b1);
      chk("midrst_in1_wait", in1_rdy, 1'b0);
      adv();

      // ---- randomized run against the model ----
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0);
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
